// File: rtl/batcharger_if.sv
// Charger controller bundle: enable/temperature, ADC sample strobe, thresholds,
// and the power-stage mode outputs.
interface batcharger_if #(parameter int TW = 16);
   logic          en;
   logic          vtok;
   logic          adc_valid;
   logic [7:0]    vbat;
   logic [7:0]    ibat;
   logic [7:0]    vpreset;
   logic [7:0]    vcv;
   logic [7:0]    vrech;
   logic [7:0]    iend;
   logic [TW-1:0] tmax;
   logic          tc;
   logic          cc;
   logic          cv;
   logic          chg_en;
   logic          done;
   logic          tout;
   logic [2:0]    state;

   modport master (
      output en, vtok, adc_valid, vbat, ibat, vpreset, vcv, vrech, iend, tmax,
      input  tc, cc, cv, chg_en, done, tout, state
   );

   modport slave (
      input  en, vtok, adc_valid, vbat, ibat, vpreset, vcv, vrech, iend, tmax,
      output tc, cc, cv, chg_en, done, tout, state
   );
endinterface

// File: rtl/batcharger_ctrl.sv
// Li-ion charge sequencer: trickle (TC), constant current (CC), constant voltage (CV),
// end-of-charge with recharge watch, plus temperature hold and sample-based timeout.
//
// state | meaning
// IDLE  | waiting for first qualifying ADC sample to pick a starting phase
// TC    | trickle charge until vbat reaches vpreset
// CC    | constant current until vbat reaches vcv
// CV    | constant voltage until ibat falls to iend
// END   | charged (or timed out); leaves when vbat sags below vrech
// WAIT  | temperature fault hold; returns to IDLE once vtok is back
module batcharger_ctrl #(
   parameter int FILT = 2,
   parameter int TW   = 16
) (
   input logic         clk,
   input logic         rst,
   batcharger_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TC   = 3'd1,
      ST_CC   = 3'd2,
      ST_CV   = 3'd3,
      ST_END  = 3'd4,
      ST_WAIT = 3'd5
   } state_t;

   localparam int              FW     = $clog2(FILT + 1);
   localparam logic [FW-1:0]   FILT_C = FW'(FILT);

   state_t        state_q, state_nx, cond_nx;
   logic [FW-1:0] fcnt_q, fcnt_nx, fcnt_inc;
   logic [TW-1:0] tcnt_q, tcnt_nx, tcnt_inc;
   logic          tout_q, tout_nx;
   logic          cond, timed, filt_hit, tmo_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
         tcnt_q  <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_nx;
         fcnt_q  <= fcnt_nx;
         tcnt_q  <= tcnt_nx;
         tout_q  <= tout_nx;
      end
   end

   always_comb begin
      cond    = 1'b0;
      cond_nx = ST_IDLE;
      case (state_q)
         ST_TC:   begin cond = (bus.vbat >= bus.vpreset); cond_nx = ST_CC;   end
         ST_CC:   begin cond = (bus.vbat >= bus.vcv);     cond_nx = ST_CV;   end
         ST_CV:   begin cond = (bus.ibat <= bus.iend);    cond_nx = ST_END;  end
         ST_END:  begin cond = (bus.vbat <  bus.vrech);   cond_nx = ST_IDLE; end
         default: ;
      endcase

      fcnt_inc = fcnt_q + 1'b1;
      tcnt_inc = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
      timed    = (state_q == ST_TC) || (state_q == ST_CV);
      filt_hit = bus.adc_valid && cond && (fcnt_inc == FILT_C);
      // timeout wins over a threshold crossing on the same sample
      tmo_hit  = bus.adc_valid && timed && (bus.tmax != '0) && (tcnt_inc == bus.tmax);

      state_nx = state_q;
      tout_nx  = tout_q;
      if (!bus.en) begin
         state_nx = ST_IDLE;
         tout_nx  = 1'b0;
      end else if (state_q > ST_WAIT) begin
         state_nx = ST_IDLE;
      end else if (!bus.vtok) begin
         state_nx = ST_WAIT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.adc_valid)
                  state_nx = (bus.vbat < bus.vpreset) ? ST_TC :
                             (bus.vbat < bus.vcv)     ? ST_CC : ST_END;
            end
            ST_TC, ST_CC, ST_CV, ST_END: begin
               if (tmo_hit) begin
                  state_nx = ST_END;
                  tout_nx  = 1'b1;
               end else if (filt_hit) begin
                  state_nx = cond_nx;
               end
            end
            ST_WAIT: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
         endcase
      end

      if (state_nx != state_q)
         fcnt_nx = '0;
      else if (bus.adc_valid)
         fcnt_nx = cond ? fcnt_inc : '0;
      else
         fcnt_nx = fcnt_q;

      if ((state_nx != state_q) && ((state_nx == ST_TC) || (state_nx == ST_CV)))
         tcnt_nx = '0;
      else if (bus.adc_valid && timed)
         tcnt_nx = tcnt_inc;
      else
         tcnt_nx = tcnt_q;
   end

   assign bus.state  = state_q;
   assign bus.tc     = (state_q == ST_TC);
   assign bus.cc     = (state_q == ST_CC);
   assign bus.cv     = (state_q == ST_CV);
   assign bus.chg_en = (state_q == ST_TC) || (state_q == ST_CC) || (state_q == ST_CV);
   assign bus.done   = (state_q == ST_END);
   assign bus.tout   = tout_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Directed charge-cycle scenarios followed by random stimulus, all checked against
// a cycle-level reference model of the charging rules.
module tb_batcharger_ctrl;
   localparam int FILT = 2;
   localparam int TW   = 16;
   localparam int TSAT = (1 << TW) - 1;

   logic clk = 1'b0;
   logic rst;

   batcharger_if #(.TW(TW)) bus ();

   batcharger_ctrl #(.FILT(FILT), .TW(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: 0 idle, 1 trickle, 2 cc, 3 cv, 4 end, 5 wait
   int m_st, m_f, m_t;
   bit m_tout;
   int vp, vc, vr, ie, tm;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit r, input bit e, input bit v, input bit av,
                        input int vb, input int ib);
      int  prev, nxt;
      bit  c, timed;
      if (r) begin
         m_st = 0; m_f = 0; m_t = 0; m_tout = 0;
         return;
      end
      prev = m_st;
      if (!e) begin
         m_st = 0;
         m_tout = 0;
      end else if (!v) begin
         m_st = 5;
      end else if (m_st == 5) begin
         m_st = 0;
      end else if (av) begin
         if (m_st == 0) begin
            m_st = (vb < vp) ? 1 : (vb < vc) ? 2 : 4;
         end else begin
            c = (m_st == 1) ? (vb >= vp) : (m_st == 2) ? (vb >= vc) :
                (m_st == 3) ? (ib <= ie) : (vb < vr);
            nxt = (m_st == 4) ? 0 : m_st + 1;
            timed = (m_st == 1) || (m_st == 3);
            if (timed && m_t < TSAT) m_t = m_t + 1;
            if (timed && tm != 0 && m_t == tm) begin
               m_st = 4;
               m_tout = 1;
            end else begin
               m_f = c ? m_f + 1 : 0;
               if (m_f == FILT) m_st = nxt;
            end
         end
      end
      if (m_st != prev) begin
         m_f = 0;
         if (m_st == 1 || m_st == 3) m_t = 0;
      end
   endtask

   function automatic logic [31:0] exp_vec();
      return 32'({3'(m_st), m_st == 1, m_st == 2, m_st == 3,
                  (m_st >= 1 && m_st <= 3), m_st == 4, m_tout});
   endfunction

   function automatic logic [31:0] obs_vec();
      return 32'({bus.state, bus.tc, bus.cc, bus.cv, bus.chg_en, bus.done, bus.tout});
   endfunction

   task automatic step(input bit r, input bit e, input bit v, input bit av,
                       input int vb, input int ib, input string tag);
      rst           = r;
      bus.en        = e;
      bus.vtok      = v;
      bus.adc_valid = av;
      bus.vbat      = 8'(vb);
      bus.ibat      = 8'(ib);
      bus.vpreset   = 8'(vp);
      bus.vcv       = 8'(vc);
      bus.vrech     = 8'(vr);
      bus.iend      = 8'(ie);
      bus.tmax      = TW'(tm);
      @(posedge clk);
      model(r, e, v, av, vb, ib);
      #1;
      chk(tag, obs_vec(), exp_vec());
   endtask

   task automatic smp(input int vb, input int ib, input string tag);
      step(1'b0, 1'b1, 1'b1, 1'b1, vb, ib, tag);
   endtask

   task automatic nop(input string tag);
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, tag);
   endtask

   task automatic reset_dut();
      step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, "reset");
   endtask

   initial begin
      bit r, e, v, av;
      vp = 153; vc = 214; vr = 200; ie = 13; tm = 0;

      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "rst0");
      reset_dut();
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_outs", 32'({bus.tc, bus.cc, bus.cv, bus.chg_en, bus.done, bus.tout}), 32'd0);
      nop("idle_hold0");
      nop("idle_hold1");
      chk("no_spont_move", 32'(bus.state), 32'd0);

      // full charge cycle
      smp(140, 50, "full_s0");
      chk("full_tc", 32'({bus.state, bus.tc}), 32'({3'd1, 1'b1}));
      smp(160, 50, "full_s1");
      chk("full_tc_filter", 32'(bus.state), 32'd1);
      smp(160, 50, "full_s2");
      chk("full_cc", 32'({bus.state, bus.cc}), 32'({3'd2, 1'b1}));
      smp(214, 50, "full_s3");
      smp(214, 50, "full_s4");
      chk("full_cv", 32'({bus.state, bus.cv}), 32'({3'd3, 1'b1}));
      smp(214, 10, "full_s5");
      chk("full_cv_filter", 32'(bus.state), 32'd3);
      smp(214, 10, "full_s6");
      chk("full_end", 32'({bus.state, bus.done, bus.tout, bus.chg_en}), 32'({3'd4, 1'b1, 1'b0, 1'b0}));

      // filter break in CC, then reset while in CV
      reset_dut();
      smp(180, 50, "brk_s0");
      chk("brk_cc", 32'(bus.state), 32'd2);
      smp(214, 50, "brk_s1");
      smp(200, 50, "brk_s2");
      smp(214, 50, "brk_s3");
      chk("brk_stay_cc", 32'(bus.state), 32'd2);
      smp(214, 50, "brk_s4");
      chk("brk_cv", 32'(bus.state), 32'd3);
      reset_dut();
      chk("rst_mid_cv", obs_vec(), 32'd0);

      // sample-count timeout in TC, then recharge keeps tout
      tm = 5;
      smp(100, 50, "tmo_s0");
      chk("tmo_tc", 32'(bus.state), 32'd1);
      repeat (4) smp(100, 50, "tmo_cnt");
      chk("tmo_before", 32'({bus.state, bus.tout}), 32'({3'd1, 1'b0}));
      smp(100, 50, "tmo_s5");
      chk("tmo_fire", 32'({bus.state, bus.tout}), 32'({3'd4, 1'b1}));
      smp(100, 50, "rech_s0");
      smp(100, 50, "rech_s1");
      chk("rech_idle_tout", 32'({bus.state, bus.tout}), 32'({3'd0, 1'b1}));

      // temperature fault
      smp(180, 50, "temp_s0");
      chk("temp_cc", 32'(bus.state), 32'd2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "temp_drop");
      chk("temp_wait", 32'({bus.state, bus.chg_en}), 32'({3'd5, 1'b0}));
      step(1'b0, 1'b1, 1'b0, 1'b1, 100, 5, "temp_ignored");
      chk("temp_wait_hold", 32'(bus.state), 32'd5);
      nop("temp_restore");
      chk("temp_idle", 32'(bus.state), 32'd0);
      smp(180, 50, "temp_s1");
      chk("temp_cc_again", 32'(bus.state), 32'd2);

      // enable drop from CV clears tout
      smp(214, 50, "en_s0");
      smp(214, 50, "en_s1");
      chk("en_cv_tout", 32'({bus.state, bus.tout}), 32'({3'd3, 1'b1}));
      step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "en_drop");
      chk("en_idle", 32'({bus.state, bus.tout}), 32'({3'd0, 1'b0}));
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 100, 5, "en_ignored");
      chk("en_ignore", 32'(bus.state), 32'd0);
      nop("en_back");
      chk("en_no_move", 32'(bus.state), 32'd0);

      // threshold equality boundaries on IDLE entry
      tm = 0;
      smp(153, 50, "bnd_vpreset");
      chk("bnd_vpreset_cc", 32'(bus.state), 32'd2);
      reset_dut();
      smp(214, 50, "bnd_vcv");
      chk("bnd_vcv_end", 32'(bus.state), 32'd4);
      reset_dut();
      smp(152, 50, "bnd_below");
      chk("bnd_below_tc", 32'(bus.state), 32'd1);

      // random phase
      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 299) == 0);
         if (r) begin
            vp = $urandom_range(40, 140);
            vc = vp + $urandom_range(5, 80);
            vr = vc - $urandom_range(0, 40);
            ie = $urandom_range(5, 40);
            tm = $urandom_range(0, 12);
         end
         e  = ($urandom_range(0, 149) != 0);
         v  = ($urandom_range(0, 59) != 0);
         av = $urandom_range(0, 1) != 0;
         step(r, e, v, av, $urandom_range(0, 255), $urandom_range(0, 60), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/batcharger_ctrl.md
BATCHARGER_CTRL -- requirements
Module: batcharger_ctrl

Interface
REQ-001 Parameter FILT, default 2, is the number of consecutive qualifying ADC samples required before a threshold transition.
REQ-002 Parameter TW, default 16, is the width of the timeout counter and of the tmax port.
REQ-003 Port clk, input, 1 bit, is the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, is the synchronous active-high reset.
REQ-005 Port en, input, 1 bit, is the charger enable.
REQ-006 Port vtok, input, 1 bit, is temperature-OK; 1 means charging is allowed.
REQ-007 Port adc_valid, input, 1 bit, is a one-cycle strobe that marks vbat and ibat as a new sample.
REQ-008 Port vbat, input, 8 bits, is the battery voltage code (code = 51*V).
REQ-009 Port ibat, input, 8 bits, is the battery current code, on the same scale as the icc/itc codes of the power stage.
REQ-010 Ports vpreset, vcv and vrech, inputs, 8 bits each, are the trickle-end, CV-entry and recharge voltage thresholds (codes).
REQ-011 Port iend, input, 8 bits, is the end-of-charge current threshold in CV.
REQ-012 Port tmax, input, TW bits, is the TC/CV timeout in adc_valid samples; tmax=0 disables the timeout.
REQ-013 Ports tc, cc and cv, outputs, 1 bit each, are the power-stage mode enables; they are one-hot or all zero.
REQ-014 Port chg_en, output, 1 bit, is the power-stage module enable.
REQ-015 Port done, output, 1 bit, is high in state END.
REQ-016 Port tout, output, 1 bit, is a sticky timeout flag.
REQ-017 Port state, output, 3 bits, is the current state encoding.

Function
REQ-018 States and encodings SHALL be IDLE=0, TC=1, CC=2, CV=3, END=4, WAIT=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-019 Outputs SHALL be decoded from the state register: tc=(TC), cc=(CC), cv=(CV), chg_en=(TC|CC|CV), done=(END); a state change at edge N is visible on outputs immediately after edge N.
REQ-020 Transition priority SHALL be rst > en=0 (to IDLE) > vtok=0 (to WAIT) > timeout > threshold transitions; en and vtok act on any cycle, independent of adc_valid.
REQ-021 IDLE SHALL act on the first adc_valid with en=1 and vtok=1, without filtering: vbat<vpreset goes to TC; vpreset<=vbat<vcv goes to CC; vbat>=vcv goes to END.
REQ-022 TC SHALL go to CC after FILT consecutive samples with vbat>=vpreset.
REQ-023 CC SHALL go to CV after FILT consecutive samples with vbat>=vcv.
REQ-024 CV SHALL go to END after FILT consecutive samples with ibat<=iend.
REQ-025 END SHALL go to IDLE after FILT consecutive samples with vbat<vrech.
REQ-026 WAIT SHALL go to IDLE on the first cycle with vtok=1 and en=1.
REQ-027 The filter counter SHALL increment only on adc_valid with the condition true, SHALL clear on adc_valid with the condition false, and SHALL clear on every state change; a transition fires on the edge of the sample that brings the count to FILT.
REQ-028 The timeout counter SHALL clear on entry to TC and on entry to CV, and SHALL increment on each adc_valid while in TC or CV.
REQ-029 In TC or CV with tmax!=0, the sample that brings the timeout count to tmax SHALL move the FSM to END and set tout; this takes priority over a threshold transition on the same sample.
REQ-030 tout SHALL stay set until rst or en=0; it SHALL NOT be cleared by the END->IDLE recharge transition.
REQ-031 Threshold compares SHALL be unsigned 8-bit; the timeout counter SHALL saturate at all-ones and never wrap.
REQ-032 adc_valid pulses in WAIT, or in IDLE with en=0, SHALL be ignored.

Reset
REQ-033 While rst=1 on a clock edge: state=IDLE, tc=cc=cv=chg_en=done=tout=0, and both counters=0.
REQ-034 Deasserting rst SHALL cause no transition until the first qualifying adc_valid.

Verification
REQ-035 Reset: assert rst mid-CV -> after the next edge state=0 and all outputs 0.
REQ-036 Full charge (FILT=2, vpreset=153, vcv=214, iend=13, tmax=0): sample vbat=140 -> TC; samples 160,160 -> CC; samples 214,214 -> CV; ibat samples 10,10 -> END with done=1 and tout=0.
REQ-037 Filter break: in CC, samples vbat=214,200,214 -> remains CC; one further 214 -> CV.
REQ-038 Timeout: tmax=5, in TC with vbat=100 -> after the 5th sample state=END and tout=1; with vrech=200, samples 100,100 -> IDLE with tout still 1.
REQ-039 Temperature fault: in CC, drop vtok -> WAIT on the next edge with chg_en=0; restore vtok -> IDLE; next sample vbat=180 -> CC.
REQ-040 Enable drop: en=0 in CV with tout=1 -> IDLE on the next edge with tout=0; adc_valid pulses ignored while en=0.
